// File: rtl/axi_pmod_gpio_pkg.sv
// Shared types and constants for the AXI4 PMOD GPIO register bank.
package axi_pmod_gpio_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [2:0] SIZE_W32    = 3'b010;

  localparam logic [31:0] OFS_ID      = 32'h000;
  localparam logic [31:0] OFS_SCRATCH = 32'h004;
  localparam logic [31:0] OFS_IN      = 32'h100;
  localparam logic [31:0] OFS_OUT     = 32'h200;
  localparam logic [31:0] OFS_EDGE    = 32'h300;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [2:0] {
    K_NONE,
    K_ID,
    K_SCR,
    K_IN,
    K_OUT,
    K_EDGE
  } reg_kind_t;

  typedef struct packed {
    reg_kind_t  kind;
    logic [2:0] ch;
  } reg_sel_t;

  function automatic logic [1:0] resp_merge(
    input logic [1:0] a,
    input logic [1:0] b
  );
    if (a == RESP_SLVERR || b == RESP_SLVERR)
      return RESP_SLVERR;
    if (a == RESP_DECERR || b == RESP_DECERR)
      return RESP_DECERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_pmod_gpio_sync.sv
// 2-FF input synchroniser with optional change detector.
// edge_o is tied low when EDGE_EN is 0.
module pmod_input_sync #(
  parameter int WIDTH   = 8,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic             clk_pll,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_pll) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

  if (EDGE_EN) begin : g_edge
    logic [WIDTH-1:0] prev_q;
    always_ff @(posedge clk_pll) begin
      if (rst) prev_q <= '0;
      else     prev_q <= sync_q;
    end
    assign edge_o = sync_q ^ prev_q;
  end else begin : g_no_edge
    assign edge_o = '0;
  end

endmodule

// File: rtl/axi_pmod_gpio.sv
// AXI4 burst slave exposing PMOD in/out registers.
// Edge capture built when AXI_PMOD_GPIO_EDGE_CAPTURE_EN is defined.
module axi_pmod_gpio
  import axi_pmod_gpio_pkg::*;
#(
  parameter int          NUM_CH   = 2,
  parameter int          ADDR_W   = 12,
  parameter int          ID_W     = 1,
  parameter logic [31:0] ID_VALUE = 32'hA7C0_0001
) (
  input  logic                aclk,
  input  logic                rst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  input  logic [NUM_CH*8-1:0] pmod_in,
  output logic [NUM_CH*8-1:0] pmod_out
);

`ifdef AXI_PMOD_GPIO_EDGE_CAPTURE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic [31:0] scratch_q;
  logic [7:0]  out_q   [8];
  logic [7:0]  sync_in [8];
  logic [7:0]  edge_w  [8];
  logic [7:0]  edge_q  [8];

  function automatic reg_sel_t decode(input logic [ADDR_W-1:0] a);
    logic [31:0] off;
    logic [31:0] lim;
    reg_sel_t    s;
    off    = 32'(a) & ~32'd3;
    lim    = 32'(4 * NUM_CH);
    s.kind = K_NONE;
    s.ch   = '0;
    unique case (1'b1)
      off == OFS_ID:      s.kind = K_ID;
      off == OFS_SCRATCH: s.kind = K_SCR;
      off >= OFS_IN && off < OFS_IN + lim: begin
        s.kind = K_IN;
        s.ch   = 3'((off - OFS_IN) >> 2);
      end
      off >= OFS_OUT && off < OFS_OUT + lim: begin
        s.kind = K_OUT;
        s.ch   = 3'((off - OFS_OUT) >> 2);
      end
      off >= OFS_EDGE && off < OFS_EDGE + lim: begin
        s.kind = K_EDGE;
        s.ch   = 3'((off - OFS_EDGE) >> 2);
      end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] sel_resp(
    input reg_sel_t s,
    input logic     size_err
  );
    if (size_err)          return RESP_SLVERR;
    if (s.kind == K_NONE)  return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [31:0] rd_val(input reg_sel_t s);
    case (s.kind)
      K_ID:    return ID_VALUE;
      K_SCR:   return scratch_q;
      K_IN:    return {24'h0, sync_in[s.ch]};
      K_OUT:   return {24'h0, out_q[s.ch]};
      K_EDGE:  return {24'h0, edge_q[s.ch]};
      default: return 32'h0;
    endcase
  endfunction

  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      pmod_input_sync #(
        .WIDTH   (8),
        .EDGE_EN (EDGE_EN)
      ) u_sync (
        .clk_pll (aclk),
        .rst     (rst),
        .d       (pmod_in[8*i +: 8]),
        .q       (sync_in[i]),
        .edge_o  (edge_w[i])
      );
      assign pmod_out[8*i +: 8] = out_q[i];
    end else begin : g_off
      assign sync_in[i] = '0;
      assign edge_w[i]  = '0;
    end
  end

  // ---------------- write channel ----------------
  wr_state_t         wr_st_q, wr_st_nx;
  logic              awready_q;
  logic [ID_W-1:0]   wid_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        wlen_q, wcnt_q;
  logic              wfixed_q, wsize_err_q;
  logic [1:0]        bresp_q;
  logic              aw_hs, w_hs, wr_en;
  reg_sel_t          wsel;
  logic [1:0]        w_resp;

  assign aw_hs = awready_q && s_axi_awvalid;
  assign w_hs  = (wr_st_q == W_DATA) && s_axi_wvalid;
  assign wr_en = w_hs && !wsize_err_q;
  assign wsel  = decode(waddr_q);

  // wlast must agree with the beat counter on every beat
  assign w_resp = resp_merge(
    sel_resp(wsel, wsize_err_q),
    (s_axi_wlast != (wcnt_q == wlen_q)) ? RESP_SLVERR : RESP_OKAY);

  always_comb begin
    wr_st_nx     = wr_st_q;
    s_axi_wready = 1'b0;
    s_axi_bvalid = 1'b0;
    unique case (wr_st_q)
      W_IDLE: if (aw_hs) wr_st_nx = W_DATA;
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (w_hs && wcnt_q == wlen_q) wr_st_nx = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_st_nx = W_IDLE;
      end
      default: wr_st_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      wr_st_q     <= W_IDLE;
      awready_q   <= 1'b0;
      wid_q       <= '0;
      waddr_q     <= '0;
      wlen_q      <= '0;
      wcnt_q      <= '0;
      wfixed_q    <= 1'b0;
      wsize_err_q <= 1'b0;
      bresp_q     <= RESP_OKAY;
    end else begin
      wr_st_q   <= wr_st_nx;
      awready_q <= (wr_st_nx == W_IDLE);
      if (aw_hs) begin
        wid_q       <= s_axi_awid;
        waddr_q     <= s_axi_awaddr;
        wlen_q      <= s_axi_awlen;
        wcnt_q      <= '0;
        wfixed_q    <= (s_axi_awburst == BURST_FIXED);
        wsize_err_q <= (s_axi_awsize != SIZE_W32);
        bresp_q     <= RESP_OKAY;
      end
      if (w_hs) begin
        bresp_q <= resp_merge(bresp_q, w_resp);
        wcnt_q  <= wcnt_q + 8'd1;
        if (!wfixed_q) waddr_q <= waddr_q + ADDR_W'(4);
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_bid     = wid_q;
  assign s_axi_bresp   = bresp_q;

  always_ff @(posedge aclk) begin
    if (rst) begin
      scratch_q <= '0;
      for (int i = 0; i < 8; i++) out_q[i] <= '0;
    end else if (wr_en) begin
      case (wsel.kind)
        K_SCR:
          for (int b = 0; b < 4; b++)
            if (s_axi_wstrb[b])
              scratch_q[8*b +: 8] <= s_axi_wdata[8*b +: 8];
        K_OUT:
          if (s_axi_wstrb[0]) out_q[wsel.ch] <= s_axi_wdata[7:0];
        default: ;
      endcase
    end
  end

`ifdef AXI_PMOD_GPIO_EDGE_CAPTURE_EN
  logic [7:0] edge_clr [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      edge_clr[i] = 8'h00;
      if (wr_en && wsel.kind == K_EDGE &&
          wsel.ch == 3'(i) && s_axi_wstrb[0])
        edge_clr[i] = s_axi_wdata[7:0];
    end
  end

  // a new edge overrides a clear in the same cycle
  always_ff @(posedge aclk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) edge_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        edge_q[i] <= (edge_q[i] & ~edge_clr[i]) | edge_w[i];
    end
  end
`else
  assign edge_q = edge_w;
`endif

  // ---------------- read channel ----------------
  rd_state_t         rd_st_q, rd_st_nx;
  logic              arready_q;
  logic [ID_W-1:0]   rid_q;
  logic [ADDR_W-1:0] raddr_q, rnext;
  logic [7:0]        rlen_q, rcnt_q;
  logic              rfixed_q, rsize_err_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic              ar_hs, r_hs, ar_size_err;
  reg_sel_t          arsel, rsel_nx;

  assign ar_hs       = arready_q && s_axi_arvalid;
  assign r_hs        = (rd_st_q == R_DATA) && s_axi_rready;
  assign ar_size_err = (s_axi_arsize != SIZE_W32);
  assign rnext       = rfixed_q ? raddr_q : raddr_q + ADDR_W'(4);
  assign arsel       = decode(s_axi_araddr);
  assign rsel_nx     = decode(rnext);

  always_comb begin
    rd_st_nx     = rd_st_q;
    s_axi_rvalid = 1'b0;
    unique case (rd_st_q)
      R_IDLE: if (ar_hs) rd_st_nx = R_DATA;
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (r_hs && rlast_q) rd_st_nx = R_IDLE;
      end
      default: rd_st_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      rd_st_q     <= R_IDLE;
      arready_q   <= 1'b0;
      rid_q       <= '0;
      raddr_q     <= '0;
      rlen_q      <= '0;
      rcnt_q      <= '0;
      rfixed_q    <= 1'b0;
      rsize_err_q <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rlast_q     <= 1'b0;
    end else begin
      rd_st_q   <= rd_st_nx;
      arready_q <= (rd_st_nx == R_IDLE);
      if (ar_hs) begin
        rid_q       <= s_axi_arid;
        raddr_q     <= s_axi_araddr;
        rlen_q      <= s_axi_arlen;
        rcnt_q      <= '0;
        rfixed_q    <= (s_axi_arburst == BURST_FIXED);
        rsize_err_q <= ar_size_err;
        rdata_q     <= rd_val(arsel);
        rresp_q     <= sel_resp(arsel, ar_size_err);
        rlast_q     <= (s_axi_arlen == 8'd0);
      end else if (r_hs && !rlast_q) begin
        raddr_q <= rnext;
        rcnt_q  <= rcnt_q + 8'd1;
        rdata_q <= rd_val(rsel_nx);
        rresp_q <= sel_resp(rsel_nx, rsize_err_q);
        rlast_q <= (rcnt_q + 8'd1 == rlen_q);
      end else if (r_hs) begin
        rlast_q <= 1'b0;
      end
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

endmodule
